// File: rtl/uart_tx_port.sv
// Serial transmit port fed by the CPU output registers: start bit, 8 data bits LSB first,
// optional even parity, and one stop bit, with a polled status byte {ovr, done, busy}.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] ctrl_in,
    output logic       tx,
    output logic [7:0] status
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_ctrl_q;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                r_par_en;
    logic                w_par_en_nxt;
    logic                r_par;
    logic                w_par_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_ovr;
    logic                w_ovr_nxt;
    logic                w_tx_nxt;
    logic                w_frame_done;
    logic                w_start_p;
    logic                w_ack_p;
    logic                w_bit_end;
    logic                w_unused_ctrl;

    assign w_start_p     = ctrl_in[0] & ~r_ctrl_q[0];
    assign w_ack_p       = ctrl_in[1] & ~r_ctrl_q[1];
    assign w_bit_end     = (r_baud == BAUD_LAST);
    assign w_unused_ctrl = ^ctrl_in[7:3];

    assign status = {5'b0, r_ovr, r_done, r_busy};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ctrl_q <= 2'b00;
            r_baud   <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            tx       <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_ctrl_q <= ctrl_in[1:0];
            r_baud   <= w_baud_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_par_en <= w_par_en_nxt;
            r_par    <= w_par_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_ovr    <= w_ovr_nxt;
            tx       <= w_tx_nxt;
        end
    end

    // Next-state, datapath and flag logic; tx/busy are derived from the next state
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_par_en_nxt = r_par_en;
        w_par_nxt    = r_par;
        w_done_nxt   = r_done;
        w_ovr_nxt    = r_ovr;
        w_frame_done = 1'b0;
        w_busy_nxt   = 1'b0;
        w_tx_nxt     = 1'b1;

        if (r_state != S_IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + BAUD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_start_p) begin
                    w_state_nxt  = S_START;
                    w_shift_nxt  = data_in;
                    w_par_en_nxt = ctrl_in[2];
                    w_par_nxt    = ^data_in;
                    w_baud_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt  = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Set beats clear for done; a start while busy is dropped and flagged
        if (w_frame_done) begin
            w_done_nxt = 1'b1;
        end else if (w_ack_p || (w_start_p && (r_state == S_IDLE))) begin
            w_done_nxt = 1'b0;
        end

        if (w_start_p && (r_state != S_IDLE)) begin
            w_ovr_nxt = 1'b1;
        end else if (w_ack_p) begin
            w_ovr_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at CLKS_PER_BIT = 4 with hand-computed frame bit patterns.
module tb_uart_tx_port;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] ctrl_in;
    logic       tx;
    logic [7:0] status;

    int n_vec;
    int n_err;

    uart_tx_port #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .ctrl_in (ctrl_in),
        .tx      (tx),
        .status  (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // bits[0] is the start bit; one check per cycle of tx and busy, then busy must drop
    task automatic expect_frame(input string tag, input logic [10:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                tick();
                check({tag, "_tx"}, 16'(tx), 16'(bits[b]));
                check({tag, "_busy"}, 16'(status[0]), 16'd1);
            end
        end
        tick();
        check({tag, "_busy_end"}, 16'(status[0]), 16'd0);
        check({tag, "_tx_end"}, 16'(tx), 16'd1);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        data_in = 8'h00;
        ctrl_in = 8'h00;
        #1;
        repeat (3) tick();
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_status", 16'(status), 16'h00);
        reset = 1'b0;
        tick();
        check("idle_tx", 16'(tx), 16'd1);
        check("idle_status", 16'(status), 16'h00);

        // 0xA5, no parity
        data_in = 8'hA5;
        ctrl_in = 8'h01;
        expect_frame("a5", 11'h34A, 10);
        check("a5_status", 16'(status), 16'h02);
        ctrl_in = 8'h00;
        tick();

        // start+ack together in IDLE, 0x07 with parity; data/parity-enable changed mid-frame
        data_in = 8'h07;
        ctrl_in = 8'h07;
        fork
            expect_frame("p07", 11'h60E, 11);
            begin
                tick();
                check("p07_st_start", 16'(status), 16'h01);
                repeat (5) tick();
                data_in = 8'hFF;
                ctrl_in = 8'h03;
            end
        join
        check("p07_status", 16'(status), 16'h02);
        ctrl_in = 8'h00;
        tick();
        ctrl_in = 8'h02;
        tick();
        check("ack_status", 16'(status), 16'h00);
        ctrl_in = 8'h00;
        tick();

        // 0x03 with parity -> parity bit 0
        data_in = 8'h03;
        ctrl_in = 8'h05;
        expect_frame("p03", 11'h406, 11);
        check("p03_status", 16'(status), 16'h02);
        ctrl_in = 8'h00;
        tick();

        // Overrun mid-frame
        data_in = 8'hA5;
        ctrl_in = 8'h01;
        fork
            expect_frame("ovr", 11'h34A, 10);
            begin
                repeat (4) tick();
                check("ovr_st_busy", 16'(status), 16'h01);
                ctrl_in = 8'h00;
                repeat (6) tick();
                ctrl_in = 8'h01;
                tick();
                check("ovr_st_set", 16'(status), 16'h05);
            end
        join
        check("ovr_st_after", 16'(status), 16'h06);
        ctrl_in = 8'h02;
        tick();
        check("ovr_ack", 16'(status), 16'h00);
        ctrl_in = 8'h00;
        tick();

        // ack on the completion edge: done set wins, ovr cleared
        data_in = 8'hA5;
        ctrl_in = 8'h01;
        fork
            expect_frame("ackend", 11'h34A, 10);
            begin
                repeat (4) tick();
                ctrl_in = 8'h00;
                repeat (6) tick();
                ctrl_in = 8'h01;
                repeat (2) tick();
                check("ackend_ovr", 16'(status), 16'h05);
                ctrl_in = 8'h00;
                repeat (28) tick();
                ctrl_in = 8'h02;
            end
        join
        check("ackend_status", 16'(status), 16'h02);
        ctrl_in = 8'h00;
        tick();

        // start on the final STOP cycle is rejected as overrun; 0x07 no parity
        data_in = 8'h07;
        ctrl_in = 8'h01;
        fork
            expect_frame("lateS", 11'h20E, 10);
            begin
                repeat (4) tick();
                ctrl_in = 8'h00;
                repeat (36) tick();
                ctrl_in = 8'h01;
            end
        join
        check("lateS_status", 16'(status), 16'h06);
        repeat (10) tick();
        check("lateS_idle", 16'({tx, status}), 16'h106);
        ctrl_in = 8'h02;
        tick();
        check("lateS_ack", 16'(status), 16'h00);
        ctrl_in = 8'h00;
        tick();

        // Held start level -> exactly one frame
        data_in = 8'hA5;
        ctrl_in = 8'h01;
        expect_frame("held", 11'h34A, 10);
        for (int i = 0; i < 160; i++) begin
            tick();
            if (i % 20 == 0) check("held_quiet", 16'({tx, status[0]}), 16'h2);
        end
        ctrl_in = 8'h00;
        tick();

        // Reset in DATA bit 3 aborts the frame
        data_in = 8'hA5;
        ctrl_in = 8'h01;
        repeat (18) tick();
        check("rstmid_busy", 16'(status[0]), 16'd1);
        reset   = 1'b1;
        ctrl_in = 8'h00;
        tick();
        check("rstmid_tx", 16'(tx), 16'd1);
        check("rstmid_status", 16'(status), 16'h00);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i % 10 == 0) check("rstmid_quiet", 16'({tx, status}), 16'h100);
        end

        // ctrl_in[0] high across reset release counts as a start
        reset   = 1'b1;
        ctrl_in = 8'h01;
        repeat (2) tick();
        reset = 1'b0;
        expect_frame("relst", 11'h34A, 10);
        check("relst_status", 16'(status), 16'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
